// File: rtl/step_dir_decoder.sv
// rtl/step_dir_decoder.sv - step/dir receive decoder with glitch filter, position counter and dir setup check
module step_dir_decoder #(
  parameter int POS_WIDTH = 32,
  parameter int FILTER    = 3,
  parameter int DIR_SETUP = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step_in,
  input  logic                 dir_in,
  input  logic                 invert_dir,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 load,
  input  logic [POS_WIDTH-1:0] load_value,
  input  logic                 err_clear,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_strobe,
  output logic                 dir_out,
  output logic                 setup_err
);

  localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);
  localparam int SW = (DIR_SETUP < 2) ? 1 : $clog2(DIR_SETUP + 1);
  // The counter switches the filtered level on the edge where it would reach FILTER.
  localparam logic [CW-1:0] FILT_LAST = CW'(FILTER - 1);
  localparam logic [SW-1:0] SETUP_MAX = SW'(DIR_SETUP);

  logic                 r_step_s1, r_step_s2, r_dir_s1, r_dir_s2;
  logic                 r_vld_s1, r_vld_s2;
  logic [CW-1:0]        r_step_cnt, r_dir_cnt;
  logic                 r_step_filt, r_dir_filt;
  logic                 r_step_armed;
  logic [SW-1:0]        r_setup_cnt;

  logic                 w_step_filt_nxt, w_dir_filt_nxt;
  logic                 w_dir_change, w_dir_eff, w_event, w_violation;

  // Two-flop synchronizers; the valid bits mark samples taken after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_dir_s1  <= 1'b0;
      r_dir_s2  <= 1'b0;
      r_vld_s1  <= 1'b0;
      r_vld_s2  <= 1'b0;
    end else begin
      r_step_s1 <= step_in;
      r_step_s2 <= r_step_s1;
      r_dir_s1  <= dir_in;
      r_dir_s2  <= r_dir_s1;
      r_vld_s1  <= 1'b1;
      r_vld_s2  <= r_vld_s1;
    end
  end

  // Filtered levels for this edge and the decoded step event.
  always_comb begin
    w_step_filt_nxt = r_step_filt;
    w_dir_filt_nxt  = r_dir_filt;
    if ((r_step_s2 != r_step_filt) && (r_step_cnt == FILT_LAST)) w_step_filt_nxt = r_step_s2;
    if ((r_dir_s2 != r_dir_filt) && (r_dir_cnt == FILT_LAST))    w_dir_filt_nxt  = r_dir_s2;
    w_dir_change = (w_dir_filt_nxt != r_dir_filt);
    w_dir_eff    = w_dir_filt_nxt ^ invert_dir;
    // A step level already high out of reset is not an edge until a real low was seen.
    w_event      = enable & r_step_armed & w_step_filt_nxt & ~r_step_filt;
    w_violation  = w_event & (w_dir_change | (r_setup_cnt < SETUP_MAX));
  end

  // Mismatch-run counters and filtered levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt  <= '0;
      r_dir_cnt   <= '0;
      r_step_filt <= 1'b0;
      r_dir_filt  <= 1'b0;
    end else begin
      r_step_filt <= w_step_filt_nxt;
      r_dir_filt  <= w_dir_filt_nxt;
      if ((r_step_s2 == r_step_filt) || (r_step_cnt == FILT_LAST)) r_step_cnt <= '0;
      else                                                          r_step_cnt <= r_step_cnt + CW'(1);
      if ((r_dir_s2 == r_dir_filt) || (r_dir_cnt == FILT_LAST))     r_dir_cnt  <= '0;
      else                                                          r_dir_cnt  <= r_dir_cnt + CW'(1);
    end
  end

  // Arming after reset and the saturating dir-stable counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_armed <= 1'b0;
      r_setup_cnt  <= SETUP_MAX;
    end else begin
      if (r_vld_s2 && !r_step_s2) r_step_armed <= 1'b1;
      if (w_dir_change)                 r_setup_cnt <= '0;
      else if (r_setup_cnt < SETUP_MAX) r_setup_cnt <= r_setup_cnt + SW'(1);
    end
  end

  // Position counter, strobe, decoded dir and sticky setup error.
  always_ff @(posedge clk) begin
    if (rst) begin
      position    <= '0;
      step_strobe <= 1'b0;
      dir_out     <= 1'b0;
      setup_err   <= 1'b0;
    end else begin
      if (clear)        position <= '0;
      else if (load)    position <= load_value;
      else if (w_event) position <= w_dir_eff ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
      step_strobe <= w_event;
      dir_out     <= w_dir_eff;
      if (w_violation)    setup_err <= 1'b1;
      else if (err_clear) setup_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
// tb/tb_step_dir_decoder.sv - self-checking bench for step_dir_decoder
module tb_step_dir_decoder;

  localparam int F  = 3;
  localparam int DS = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_in = 1'b0, dir_in = 1'b0, invert_dir = 1'b0, enable = 1'b1;
  logic        clear = 1'b0, load = 1'b0, err_clear = 1'b0;
  logic [31:0] load_value = '0;
  logic [31:0] position;
  logic        step_strobe, dir_out, setup_err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  bit chk_en = 1'b0;

  step_dir_decoder #(.POS_WIDTH(32), .FILTER(F), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst(rst), .step_in(step_in), .dir_in(dir_in), .invert_dir(invert_dir),
    .enable(enable), .clear(clear), .load(load), .load_value(load_value),
    .err_clear(err_clear), .position(position), .step_strobe(step_strobe),
    .dir_out(dir_out), .setup_err(setup_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last F samples that reached
  // the filter (input sampled two edges earlier and before) all disagree with it.
  bit          hs[0:F], hd[0:F], hv[0:F];
  bit          mf_step, mf_dir, m_armed, m_strobe, m_dirout, m_err;
  int          m_stable;
  logic [31:0] m_pos;

  always @(posedge clk) begin
    bit all_s, all_d, nf_s, nf_d, ev, dchg, deff;
    if (rst) begin
      for (int i = 0; i <= F; i++) begin hs[i] = 0; hd[i] = 0; hv[i] = 0; end
      mf_step = 0; mf_dir = 0; m_armed = 0; m_strobe = 0; m_dirout = 0; m_err = 0;
      m_stable = DS; m_pos = '0;
    end else begin
      all_s = 1; all_d = 1;
      for (int i = 1; i <= F; i++) begin
        if (hs[i] == mf_step) all_s = 0;
        if (hd[i] == mf_dir)  all_d = 0;
      end
      nf_s = all_s ? ~mf_step : mf_step;
      nf_d = all_d ? ~mf_dir  : mf_dir;
      ev   = enable && m_armed && nf_s && !mf_step;
      dchg = (nf_d != mf_dir);
      deff = nf_d ^ invert_dir;
      if (clear)     m_pos = '0;
      else if (load) m_pos = load_value;
      else if (ev)   m_pos = deff ? m_pos + 32'd1 : m_pos - 32'd1;
      m_strobe = ev;
      m_dirout = deff;
      if (ev && (dchg || m_stable < DS)) m_err = 1;
      else if (err_clear)                m_err = 0;
      if (dchg)               m_stable = 0;
      else if (m_stable < DS) m_stable++;
      if (hv[1] && !hs[1]) m_armed = 1;
      mf_step = nf_s; mf_dir = nf_d;
      for (int i = F; i >= 1; i--) begin hs[i] = hs[i-1]; hd[i] = hd[i-1]; hv[i] = hv[i-1]; end
      hs[0] = step_in; hd[0] = dir_in; hv[0] = 1;
    end
  end

  // Every cycle the DUT is compared against the model away from the active edge.
  always @(negedge clk) begin
    if (step_strobe === 1'b1) n_strobe++;
    if (chk_en) begin
      check_eq("position", position, m_pos);
      check_eq("step_strobe", 32'(step_strobe), 32'(m_strobe));
      check_eq("dir_out", 32'(dir_out), 32'(m_dirout));
      check_eq("setup_err", 32'(setup_err), 32'(m_err));
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic step_pulse(input int hi, input int lo);
    step_in = 1'b1;
    repeat (hi) tick;
    step_in = 1'b0;
    repeat (lo) tick;
  endtask

  initial begin
    int lat, s0, hold;
    logic [31:0] p0;

    repeat (3) tick;
    chk_en = 1'b1;
    check_eq("reset_position", position, 32'h0);
    check_eq("reset_setup_err", 32'(setup_err), 32'h0);
    check_eq("reset_dir_out", 32'(dir_out), 32'h0);
    rst = 1'b0;

    // Basic step after reset and latency.
    dir_in = 1'b1;
    repeat (40) tick;
    step_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick;
      if (step_strobe) lat = i;
    end
    check_eq("t1_latency", 32'(lat), 32'd5);
    repeat (5) tick;
    step_in = 1'b0;
    repeat (10) tick;
    check_eq("t1_position", position, 32'd1);
    check_eq("t1_setup_err", 32'(setup_err), 32'd0);

    // Glitch shorter than the filter.
    p0 = position; s0 = n_strobe;
    step_pulse(2, 10);
    check_eq("t2_strobes", 32'(n_strobe - s0), 32'd0);
    check_eq("t2_position", position, p0);

    // Direction and wrap-around.
    load_value = 32'h7FFF_FFFF; load = 1'b1; tick; load = 1'b0; tick;
    step_pulse(8, 10);
    check_eq("t3_wrap_up", position, 32'h8000_0000);
    clear = 1'b1; tick; clear = 1'b0;
    dir_in = 1'b0;
    repeat (40) tick;
    step_pulse(8, 10);
    check_eq("t3_wrap_down", position, 32'hFFFF_FFFF);
    clear = 1'b1; tick; clear = 1'b0;
    invert_dir = 1'b1;
    repeat (40) tick;
    step_pulse(8, 10);
    check_eq("t3_inverted", position, 32'h0000_0001);
    invert_dir = 1'b0;
    repeat (40) tick;

    // Dir-to-step setup check.
    dir_in = 1'b1;
    repeat (10) tick;
    step_pulse(8, 10);
    check_eq("t4_err_set", 32'(setup_err), 32'd1);
    err_clear = 1'b1; tick; err_clear = 1'b0; tick;
    check_eq("t4_err_cleared", 32'(setup_err), 32'd0);
    repeat (30) tick;
    step_pulse(8, 10);
    check_eq("t4_err_stays", 32'(setup_err), 32'd0);

    // Priority of clear/load over a coinciding step event.
    load_value = 32'h100;
    step_in = 1'b1;
    repeat (4) tick;
    load = 1'b1; tick; load = 1'b0;
    check_eq("t5_load_strobe", 32'(step_strobe), 32'd1);
    check_eq("t5_load_pos", position, 32'h100);
    step_in = 1'b0;
    repeat (10) tick;
    step_in = 1'b1;
    repeat (4) tick;
    clear = 1'b1; load = 1'b1; tick; clear = 1'b0; load = 1'b0;
    check_eq("t5_clear_strobe", 32'(step_strobe), 32'd1);
    check_eq("t5_clear_pos", position, 32'h0);
    step_in = 1'b0;
    repeat (10) tick;

    // Disabled counting, then reset with step held high.
    enable = 1'b0;
    p0 = position; s0 = n_strobe;
    repeat (5) step_pulse(8, 8);
    check_eq("t6_disabled_pos", position, p0);
    check_eq("t6_disabled_strobes", 32'(n_strobe - s0), 32'd0);
    enable = 1'b1;
    step_in = 1'b1;
    repeat (10) tick;
    rst = 1'b1; tick; rst = 1'b0;
    s0 = n_strobe;
    repeat (30) tick;
    check_eq("t6_no_strobe_after_rst", 32'(n_strobe - s0), 32'd0);
    check_eq("t6_pos_after_rst", position, 32'h0);
    step_in = 1'b0;
    repeat (10) tick;
    step_in = 1'b1;
    repeat (10) tick;
    check_eq("t6_strobe_after_retoggle", 32'(n_strobe - s0), 32'd1);
    step_in = 1'b0;
    repeat (10) tick;

    // Randomized traffic against the model.
    hold = 1;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        step_in = ~step_in;
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 39) == 0) dir_in = ~dir_in;
      if ($urandom_range(0, 199) == 0) invert_dir = ~invert_dir;
      enable     = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 99) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFE + 32'($urandom_range(0, 3)) : $urandom;
      err_clear  = ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      tick;
    end
    rst = 1'b0; clear = 1'b0; load = 1'b0; err_clear = 1'b0;
    repeat (5) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
